// File: rtl/pce_pkg.sv
// Shared types and default memory map for the pattern count engine.
package pce_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PAT,
    SCAN,
    DRAIN,
    WR0,
    WR1,
    WR2,
    DONE
  } pce_state_e;

  localparam int unsigned DEF_N_BYTES   = 32;
  localparam int unsigned DEF_BASE_ADDR = 0;
  localparam int unsigned DEF_PAT_ADDR  = 32;
  localparam int unsigned DEF_RES_ADDR  = 33;
  localparam int unsigned DEF_AW        = 8;

endpackage

// File: rtl/pat_window_match.sv
// Counts 5-bit pattern hits in one byte and in the four windows straddling
// the previous byte / current byte boundary.
module pat_window_match
  import pce_pkg::*;
(
  input  logic [4:0] p,
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic       any_in,
  output logic [2:0] x_cnt
);

  logic [15:0] s;
  assign s = {prev, cur};

  // Offsets 0..3 lie wholly inside cur; offsets 4..7 reach into prev.
  always_comb begin
    in_cnt = '0;
    x_cnt  = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i +: 5] == p) in_cnt = in_cnt + 3'd1;
    end
    for (int i = 4; i < 8; i++) begin
      if (!first && (s[i +: 5] == p)) x_cnt = x_cnt + 3'd1;
    end
    any_in = (in_cnt != 3'd0);
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Memory-master engine: reads a pattern and message, counts pattern matches
// three ways and writes the counts back, then raises done.
module pattern_count_engine
  import pce_pkg::*;
#(
  parameter int unsigned N_BYTES   = DEF_N_BYTES,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned PAT_ADDR  = DEF_PAT_ADDR,
  parameter int unsigned RES_ADDR  = DEF_RES_ADDR,
  parameter int unsigned AW        = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata
);

  localparam int unsigned IW = $clog2(N_BYTES + 1);

  pce_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4:0]    pat_q, pat_d;
  logic [7:0]    prev_q, prev_d;
  logic          first_q, first_d;
  logic          rvalid_q, rvalid_d;
  logic          rpat_q, rpat_d;
  logic [7:0]    ctb_q, ctb_d;
  logic [7:0]    cto_q, cto_d;
  logic [7:0]    cts_q, cts_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wdata_q, wdata_d;

  logic [2:0] in_cnt;
  logic       any_in;
  logic [2:0] x_cnt;

  pat_window_match u_match (
    .p      (pat_q),
    .prev   (prev_q),
    .cur    (mem_rdata),
    .first  (first_q),
    .in_cnt (in_cnt),
    .any_in (any_in),
    .x_cnt  (x_cnt)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    prev_d   = prev_q;
    first_d  = first_q;
    ctb_d    = ctb_q;
    cto_d    = cto_q;
    cts_d    = cts_q;
    done_d   = done_q;
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    wr_en_d  = 1'b0;
    wdata_d  = wdata_q;
    rvalid_d = rd_en_q;
    rpat_d   = (state_q == RD_PAT);

    // Read data lands one cycle after the strobe; the pattern read comes first.
    if (rvalid_q && rpat_q) begin
      pat_d   = mem_rdata[7:3];
      first_d = 1'b1;
    end else if (rvalid_q) begin
      ctb_d   = ctb_q + {5'd0, in_cnt};
      cto_d   = cto_q + {7'd0, any_in};
      cts_d   = cts_q + {5'd0, in_cnt} + {5'd0, x_cnt};
      prev_d  = mem_rdata;
      first_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = RD_PAT;
          addr_d  = AW'(PAT_ADDR);
          rd_en_d = 1'b1;
          done_d  = 1'b0;
          idx_d   = '0;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
        end
      end
      RD_PAT: begin
        state_d = SCAN;
        addr_d  = AW'(BASE_ADDR);
        rd_en_d = 1'b1;
        idx_d   = IW'(1);
      end
      SCAN: begin
        if (idx_q == IW'(N_BYTES)) begin
          state_d = DRAIN;
        end else begin
          addr_d  = AW'(BASE_ADDR) + AW'(idx_q);
          rd_en_d = 1'b1;
          idx_d   = idx_q + IW'(1);
        end
      end
      DRAIN: begin
        state_d = WR0;
        addr_d  = AW'(RES_ADDR);
        wr_en_d = 1'b1;
        wdata_d = ctb_d;
      end
      WR0: begin
        state_d = WR1;
        addr_d  = AW'(RES_ADDR + 1);
        wr_en_d = 1'b1;
        wdata_d = cto_q;
      end
      WR1: begin
        state_d = WR2;
        addr_d  = AW'(RES_ADDR + 2);
        wr_en_d = 1'b1;
        wdata_d = cts_q;
      end
      WR2: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pat_q    <= '0;
      prev_q   <= '0;
      first_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rpat_q   <= 1'b0;
      ctb_q    <= '0;
      cto_q    <= '0;
      cts_q    <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      prev_q   <= prev_d;
      first_q  <= first_d;
      rvalid_q <= rvalid_d;
      rpat_q   <= rpat_d;
      ctb_q    <= ctb_d;
      cto_q    <= cto_d;
      cts_q    <= cts_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      wdata_q  <= wdata_d;
    end
  end

  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Scoreboard bench for pattern_count_engine with a stream-level reference model.
module tb_pattern_count_engine;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  logic [7:0] mem [0:255];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  pattern_count_engine dut (
    .clk       (clk),
    .reset     (rst_n),
    .req       (req),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Counts every 5-bit window of the whole message treated as one bit stream.
  function automatic void ref_model(output int ctb, output int cto, output int cts);
    logic [255:0] st;
    logic [4:0]   p;
    int           hits;
    p   = mem[32][7:3];
    ctb = 0;
    cto = 0;
    cts = 0;
    st  = '0;
    for (int i = 0; i < N; i++) begin
      st[255 - 8*i -: 8] = mem[i];
      hits = 0;
      for (int sh = 0; sh < 4; sh++) begin
        if (5'(mem[i] >> sh) == p) hits++;
      end
      ctb += hits;
      if (hits > 0) cto++;
    end
    for (int pos = 0; pos <= 8*N - 5; pos++) begin
      if (st[pos +: 5] == p) cts++;
    end
  endfunction

  task automatic push_exp(input int s);
    int a, b, c;
    ref_model(a, b, c);
    sb.push_back('{33, a, s + N + 2});
    sb.push_back('{34, b, s + N + 3});
    sb.push_back('{35, c, s + N + 4});
  endtask

  task automatic start_run(output int s);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    s = cyc;
    @(negedge clk);
    chk("done_drop", int'(done), 0);
  endtask

  task automatic wait_done(input string name, input int s);
    for (int k = 0; k < 100; k++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(name, cyc - s + 1, 38);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  task automatic set_pat(input logic [4:0] p);
    mem[32] = {p, 3'($urandom)};
  endtask

  task automatic normal_run(input string name);
    int s;
    start_run(s);
    push_exp(s);
    wait_done(name, s);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_wr_en) begin
        checks++;
        if (mem_rd_en) begin
          failures++;
          $display("FAIL rd_wr_overlap addr=%0d", mem_addr);
        end
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", mem_addr, mem_wdata, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(mem_addr) != e.addr || int'(mem_wdata) != e.data || cyc != e.cyc) begin
            failures++;
            $display("FAIL result_write got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                     mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    int s;
    fork
      forever begin
        @(posedge clk);
        cyc = cyc + 1;
      end
      monitor();
    join_none

    rst_n = 1'b0;
    req   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_pat(5'b00000); set_all(8'h00);
    normal_run("t1_all_zero");

    set_pat(5'b10101); set_all(8'h55);
    normal_run("t2_alt");

    set_pat(5'b11111); set_all(8'h00); mem[5] = 8'hFF;
    normal_run("t3_single_ff");

    set_pat(5'b11111); set_all(8'h00); mem[3] = 8'h0F; mem[4] = 8'hF0;
    normal_run("t4_crossing");

    // Extra req mid-run must be ignored.
    set_pat(5'b01100); for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    start_run(s);
    push_exp(s);
    repeat (9) @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done("t5_req_busy", s);

    // Reset abort at cycle 20: no writes, done stays low, no self-restart.
    set_pat(5'b11111); set_all(8'hFF);
    start_run(s);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_done", int'(done), 0);
    chk("abort_wr_en", int'(mem_wr_en), 0);
    chk("abort_rd_en", int'(mem_rd_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle_done", int'(done), 0);
    chk("abort_idle_rd", int'(mem_rd_en), 0);
    normal_run("t6_after_abort");

    // req held high: back-to-back runs, done high for one cycle only.
    set_pat(5'b10011); for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    push_exp(s);
    push_exp(s + 38);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("hold_first_done", cyc - s + 1, 38);
    @(negedge clk);
    chk("hold_done_one_cycle", int'(done), 0);
    req = 1'b0;
    wait_done("hold_second_done", s + 38);

    for (int r = 0; r < 8; r++) begin
      set_pat(5'($urandom));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 4))
          0: mem[i] = 8'h00;
          1: mem[i] = 8'hFF;
          2: mem[i] = 8'h55;
          3: mem[i] = 8'hAA;
          default: mem[i] = 8'($urandom);
        endcase
      end
      normal_run($sformatf("rand_%0d", r));
    end

    repeat (5) @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
